// File: rtl/hilo_muldiv_if.sv
// hilo_muldiv_if: request/result bundle between EX/decode (master) and the HI/LO mul-div unit (slave)
interface hilo_muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output start, op, a, b, flush, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning HI/LO; ports clk, rst_n (async low), io (slave: start/op/a/b/flush in, busy/done/hi/lo out); HILO_FAST_MUL_EN selects a single-cycle multiplier
module hilo_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic         clk,
  input logic         rst_n,
  hilo_muldiv_if.slave io
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, p_q, p_d, l_q, l_d, m_q, m_d;
  logic div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, done_q, done_d;
  logic sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, step_p, step_l;
  logic [WIDTH:0] sum, shl, diff;
  logic [2*WIDTH-1:0] prod;
  assign sgn   = ~io.op[0];
  assign a_neg = sgn & io.a[WIDTH-1];
  assign b_neg = sgn & io.b[WIDTH-1];
  assign a_mag = a_neg ? -io.a : io.a;
  assign b_mag = b_neg ? -io.b : io.b;
  // p_q is the running upper half (multiply) or partial remainder (divide);
  // l_q holds the multiplier shifting out / dividend shifting into the quotient
  assign sum    = {1'b0, p_q} + {1'b0, (l_q[0] ? m_q : {WIDTH{1'b0}})};
  assign shl    = {p_q, l_q[WIDTH-1]};
  assign diff   = shl - {1'b0, m_q};
  assign step_p = div_q ? (diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
  assign step_l = div_q ? {l_q[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], l_q[WIDTH-1:1]};
  assign prod   = neg_q ? -{step_p, step_l} : {step_p, step_l};
`ifdef HILO_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast;
  assign fast = {{WIDTH{a_neg}}, io.a} * {{WIDTH{b_neg}}, io.b};
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    p_d     = p_q;
    l_d     = l_q;
    m_d     = m_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (io.start && !io.flush) begin
        if (io.op == 3'd4) begin
          hi_d   = io.a;
          done_d = 1'b1;
        end else if (io.op == 3'd5) begin
          lo_d   = io.a;
          done_d = 1'b1;
        end else if (io.op[2:1] == 2'b01 && io.b == '0) begin
          hi_d   = io.a;
          lo_d   = '1;
          done_d = 1'b1;
`ifdef HILO_FAST_MUL_EN
        end else if (io.op[2:1] == 2'b00) begin
          {hi_d, lo_d} = fast;
          done_d       = 1'b1;
`endif
        end else if (!io.op[2]) begin
          state_d = RUN;
          cnt_d   = '0;
          p_d     = '0;
          l_d     = a_mag;
          m_d     = b_mag;
          div_d   = io.op[1];
          neg_d   = a_neg ^ b_neg;
          rneg_d  = a_neg;
        end
      end
    end else if (io.flush) begin
      state_d = IDLE;
    end else begin
      p_d   = step_p;
      l_d   = step_l;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
        hi_d    = div_q ? (rneg_q ? -step_p : step_p) : prod[2*WIDTH-1:WIDTH];
        lo_d    = div_q ? (neg_q ? -step_l : step_l) : prod[WIDTH-1:0];
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      p_q     <= '0;
      l_q     <= '0;
      m_q     <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      p_q     <= p_d;
      l_q     <= l_d;
      m_q     <= m_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      done_q  <= done_d;
    end
  end
  assign io.busy = (state_q == RUN);
  assign io.done = done_q;
  assign io.hi   = hi_q;
  assign io.lo   = lo_q;
endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: randomized and directed checks of hilo_muldiv against an arithmetic reference model
module tb_hilo_muldiv;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;
`ifdef HILO_FAST_MUL_EN
  localparam int MUL_CYC = 0;
`else
  localparam int MUL_CYC = 32;
`endif
  hilo_muldiv_if #(.WIDTH(32)) m ();
  hilo_muldiv #(.WIDTH(32), .CNT_W(6)) dut (.clk(clk), .rst_n(rst_n), .io(m));
  always #5 clk = ~clk;

  function automatic void model(input logic [2:0] o, input logic [31:0] av, bv, inout logic [31:0] h, l);
    longint sa, sb;
    logic [63:0] p;
    sa = $signed(av);
    sb = $signed(bv);
    case (o)
      3'd0: begin p = 64'(sa * sb); {h, l} = p; end
      3'd1: begin p = {32'b0, av} * {32'b0, bv}; {h, l} = p; end
      3'd2: if (bv == 0) begin h = av; l = '1; end else begin l = 32'(sa / sb); h = 32'(sa % sb); end
      3'd3: if (bv == 0) begin h = av; l = '1; end else begin l = av / bv; h = av % bv; end
      3'd4: h = av;
      3'd5: l = av;
      default: ;
    endcase
  endfunction

  function automatic int cycles_for(input logic [2:0] o, input logic [31:0] bv);
    return (o < 2) ? MUL_CYC : ((o < 4 && bv != 0) ? 32 : 0);
  endfunction

  // drives one request and observes the response; comparisons are left to the callers
  task automatic run_op(input logic [2:0] o, input logic [31:0] av, bv, output int busy_n, output bit got,
                        output bit both, output bit early, output bit pulse_ok, output logic [31:0] rh, rl);
    logic [31:0] h0, l0;
    h0 = m.hi;
    l0 = m.lo;
    @(negedge clk);
    m.start = 1'b1; m.op = o; m.a = av; m.b = bv;
    @(negedge clk);
    m.start = 1'b0;
    busy_n = 0; got = 0; both = 0; early = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (m.busy && m.done) both = 1;
      if (m.done) got = 1;
      else begin
        if (m.busy) busy_n++;
        if (m.hi !== h0 || m.lo !== l0) early = 1;
        @(negedge clk);
      end
    end
    rh = m.hi;
    rl = m.lo;
    @(negedge clk);
    pulse_ok = !m.done && !m.busy;
  endtask

  task automatic test_reset;
    n_vec++;
    if ({m.busy, m.done, m.hi, m.lo} !== 66'b0) begin
      n_err++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, required all zero", m.busy, m.done, m.hi, m.lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({m.busy, m.done, m.hi, m.lo} !== 66'b0) begin
      n_err++;
      $display("FAIL post_reset: busy=%b done=%b hi=%h lo=%h, required all zero", m.busy, m.done, m.hi, m.lo);
    end
  endtask

  task automatic check_op(input string name, input logic [2:0] o, input logic [31:0] av, bv);
    int bn; bit got, both, early, pok;
    logic [31:0] rh, rl;
    run_op(o, av, bv, bn, got, both, early, pok, rh, rl);
    model(o, av, bv, exp_hi, exp_lo);
    n_vec++;
    if (!got || both || early || !pok || bn != cycles_for(o, bv) || rh !== exp_hi || rl !== exp_lo) begin
      n_err++;
      $display("FAIL %s op=%0d a=%h b=%h: hi=%h lo=%h busy_cycles=%0d done=%b overlap=%b early=%b single=%b, required hi=%h lo=%h busy_cycles=%0d",
               name, o, av, bv, rh, rl, bn, got, both, early, pok, exp_hi, exp_lo, cycles_for(o, bv));
    end
  endtask

  task automatic test_move;
    check_op("mthi", 3'd4, 32'h12345678, 32'h0);
    check_op("mtlo", 3'd5, 32'h9ABCDEF0, 32'h0);
  endtask

  task automatic test_mul;
    check_op("mult_neg", 3'd0, 32'hFFFFFFFE, 32'h3);
    check_op("multu", 3'd1, 32'hFFFFFFFE, 32'h3);
    check_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check_op("mult_min", 3'd0, 32'h80000000, 32'h80000000);
    for (int i = 0; i < 12; i++) check_op("mul_rand", 3'($urandom_range(0, 1)), $urandom, $urandom);
  endtask

  task automatic test_div;
    check_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'h2);
    check_op("divu", 3'd3, 32'd100, 32'd7);
    check_op("divu_zero", 3'd3, 32'd5, 32'd0);
    check_op("div_zero", 3'd2, 32'hFFFFFFF0, 32'd0);
    check_op("div_wrap", 3'd2, 32'h80000000, 32'hFFFFFFFF);
    check_op("divu_big", 3'd3, 32'hFFFFFFFF, 32'h1);
    for (int i = 0; i < 16; i++)
      check_op("div_rand", 3'($urandom_range(2, 3)), $urandom,
               (i % 4 == 0) ? 32'($urandom_range(0, 9)) : ((i % 4 == 1) ? $urandom >> $urandom_range(0, 31) : $urandom));
  endtask

  task automatic test_flush;
    @(negedge clk);
    m.start = 1'b1; m.op = 3'd3; m.a = $urandom; m.b = 32'd13;
    @(negedge clk);
    m.start = 1'b0;
    n_vec++;
    if (m.busy !== 1'b1) begin n_err++; $display("FAIL flush_busy_start: busy=%b, required 1", m.busy); end
    repeat (3) @(negedge clk);
    m.start = 1'b1; m.op = 3'd4; m.a = 32'hDEADBEEF;
    @(negedge clk);
    m.start = 1'b0;
    repeat (5) @(negedge clk);
    m.flush = 1'b1;
    @(negedge clk);
    m.flush = 1'b0;
    n_vec++;
    if (m.busy !== 1'b0 || m.done !== 1'b0 || m.hi !== exp_hi || m.lo !== exp_lo) begin
      n_err++;
      $display("FAIL flush_mid: busy=%b done=%b hi=%h lo=%h, required busy=0 done=0 hi=%h lo=%h", m.busy, m.done, m.hi, m.lo, exp_hi, exp_lo);
    end
    @(negedge clk);
    n_vec++;
    if (m.done !== 1'b0 || m.hi !== exp_hi) begin
      n_err++;
      $display("FAIL flush_after: done=%b hi=%h, required done=0 hi=%h", m.done, m.hi, exp_hi);
    end
    // flush coinciding with the final iteration edge must still discard the result
    @(negedge clk);
    m.start = 1'b1; m.op = 3'd2; m.a = 32'h7FFF0000; m.b = 32'd3;
    @(negedge clk);
    m.start = 1'b0;
    repeat (31) @(negedge clk);
    n_vec++;
    if (m.busy !== 1'b1 || m.done !== 1'b0) begin
      n_err++;
      $display("FAIL flush_last_pre: busy=%b done=%b, required busy=1 done=0", m.busy, m.done);
    end
    m.flush = 1'b1;
    @(negedge clk);
    m.flush = 1'b0;
    n_vec++;
    if (m.busy !== 1'b0 || m.done !== 1'b0 || m.hi !== exp_hi || m.lo !== exp_lo) begin
      n_err++;
      $display("FAIL flush_last: busy=%b done=%b hi=%h lo=%h, required busy=0 done=0 hi=%h lo=%h", m.busy, m.done, m.hi, m.lo, exp_hi, exp_lo);
    end
  endtask

  task automatic test_ignored;
    @(negedge clk);
    m.start = 1'b1; m.op = 3'd4; m.a = 32'hCAFEF00D; m.flush = 1'b1;
    @(negedge clk);
    m.start = 1'b0; m.flush = 1'b0;
    n_vec++;
    if (m.done !== 1'b0 || m.hi !== exp_hi) begin
      n_err++;
      $display("FAIL idle_flush_start: done=%b hi=%h, required done=0 hi=%h", m.done, m.hi, exp_hi);
    end
    for (int o = 6; o < 8; o++) begin
      @(negedge clk);
      m.start = 1'b1; m.op = 3'(o); m.a = $urandom; m.b = $urandom;
      @(negedge clk);
      m.start = 1'b0;
      n_vec++;
      if (m.done !== 1'b0 || m.busy !== 1'b0 || m.hi !== exp_hi || m.lo !== exp_lo) begin
        n_err++;
        $display("FAIL bad_op%0d: done=%b busy=%b hi=%h lo=%h, required done=0 busy=0 hi=%h lo=%h", o, m.done, m.busy, m.hi, m.lo, exp_hi, exp_lo);
      end
    end
  endtask

  task automatic test_async_reset;
    bit seen;
    check_op("mthi_pre", 3'd4, 32'hA5A5A5A5, 32'h0);
    @(negedge clk);
    m.start = 1'b1; m.op = 3'd2; m.a = 32'h12345; m.b = 32'd7;
    @(negedge clk);
    m.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({m.busy, m.done, m.hi, m.lo} !== 66'b0) begin
      n_err++;
      $display("FAIL async_reset: busy=%b done=%b hi=%h lo=%h, required all zero", m.busy, m.done, m.hi, m.lo);
    end
    exp_hi = '0;
    exp_lo = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (m.done || m.busy) seen = 1;
    end
    n_vec++;
    if (seen) begin n_err++; $display("FAIL reset_discard: done/busy=1 seen after reset, required none"); end
    check_op("divu_after_reset", 3'd3, 32'd9, 32'd3);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 10; i++) check_op("mix_rand", 3'($urandom_range(0, 5)), $urandom, (i % 3 == 0) ? 32'd0 : $urandom);
    check_op("multu_fast", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
  endtask

  initial begin
    m.start = 1'b0; m.op = '0; m.a = '0; m.b = '0; m.flush = 1'b0;
    #1;
    test_reset();
    test_move();
    test_mul();
    test_div();
    test_flush();
    test_ignored();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
